// File: rtl/fp32_pkg.sv
// ============================================================================
// fp32_pkg : shared constants and types for the fp32 -> int32 converter
// Revision : 1.0
// ============================================================================
`default_nettype none

package fp32_pkg;

  localparam int FP32_BIAS  = 127;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;

  localparam int FLAG_INVALID  = 2;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_INEXACT  = 0;

  localparam logic RND_RTZ = 1'b0;
  localparam logic RND_RNE = 1'b1;

  typedef enum logic [1:0] {
    FP_ZERO   = 2'd0,
    FP_NORMAL = 2'd1,
    FP_INF    = 2'd2,
    FP_NAN    = 2'd3
  } fp_class_e;

endpackage

`default_nettype wire

// File: rtl/fp32_unpack.sv
// ============================================================================
// fp32_unpack : combinational classify/align stage; yields the truncated
//               integer part plus guard and sticky bits for rounding
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fp32_unpack
  import fp32_pkg::*;
(
  input  logic [31:0] i_data,
  output fp_class_e   o_class,
  output logic        o_sign,
  output logic        o_big,
  output logic        o_is_min,
  output logic [30:0] o_int,
  output logic        o_guard,
  output logic        o_sticky
);

  localparam logic [FP32_EXP_W-1:0] EXP_ONE   = FP32_EXP_W'(FP32_BIAS);
  localparam logic [FP32_EXP_W-1:0] EXP_HALF  = FP32_EXP_W'(FP32_BIAS - 1);
  localparam logic [FP32_EXP_W-1:0] EXP_EXACT = FP32_EXP_W'(FP32_BIAS + FP32_MAN_W);
  localparam logic [FP32_EXP_W-1:0] EXP_SAT   = FP32_EXP_W'(FP32_BIAS + 31);

  logic [FP32_EXP_W-1:0] w_exp;
  logic [FP32_MAN_W-1:0] w_man;
  logic [FP32_MAN_W:0]   w_m;
  logic [7:0]            w_rs;
  logic [7:0]            w_ls;
  logic [FP32_MAN_W:0]   w_shr;
  logic [FP32_MAN_W:0]   w_grd;
  logic [FP32_MAN_W:0]   w_low;
  logic [30:0]           w_shl;

  assign o_sign   = i_data[31];
  assign w_exp    = i_data[30:23];
  assign w_man    = i_data[22:0];
  assign w_m      = {1'b1, w_man};
  assign o_is_min = (i_data == 32'hCF00_0000);

  // Shift amounts are only meaningful inside the exponent window that uses them.
  assign w_rs  = EXP_EXACT - w_exp;
  assign w_ls  = w_exp - EXP_EXACT;
  assign w_shr = w_m >> w_rs;
  assign w_grd = w_m >> (w_rs - 8'd1);
  assign w_low = w_m << (8'd25 - w_rs);
  assign w_shl = {7'b0, w_m} << w_ls;

  always_comb begin
    o_class  = FP_NORMAL;
    o_big    = 1'b0;
    o_int    = '0;
    o_guard  = 1'b0;
    o_sticky = 1'b0;
    if (w_exp == '0) begin
      o_class  = FP_ZERO;
      o_sticky = |w_man;
    end else if (w_exp == '1) begin
      o_class = (w_man != '0) ? FP_NAN : FP_INF;
    end else if (w_exp >= EXP_SAT) begin
      o_big = 1'b1;
    end else if (w_exp >= EXP_EXACT) begin
      o_int = w_shl;
    end else if (w_exp >= EXP_ONE) begin
      o_int    = {7'b0, w_shr};
      o_guard  = w_grd[0];
      o_sticky = |w_low;
    end else begin
      o_guard  = (w_exp == EXP_HALF);
      o_sticky = (w_exp == EXP_HALF) ? |w_man : 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp32_to_int32.sv
// ============================================================================
// fp32_to_int32 : two-stage fp32 -> int32 converter with valid/ready on both
//                 sides; RNE/RTZ rounding, saturation and exception flags
// Revision      : 1.0
// ============================================================================
`default_nettype none

module fp32_to_int32
  import fp32_pkg::*;
#(
  parameter logic [31:0] NAN_VALUE = 32'h7FFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_rnd_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_flags
);

  fp_class_e   w_class;
  logic        w_sign, w_big, w_is_min, w_guard, w_sticky;
  logic [30:0] w_int;

  fp_class_e   r_s1_class;
  logic        r_s1_valid, r_s1_rnd, r_s1_sign, r_s1_big, r_s1_min;
  logic        r_s1_guard, r_s1_sticky;
  logic [30:0] r_s1_int;

  logic        w_s1_adv, w_s2_adv, w_inc;
  logic [31:0] w_mag, w_data;
  logic [2:0]  w_flags;

  fp32_unpack u_unpack (
    .i_data   (in_data),
    .o_class  (w_class),
    .o_sign   (w_sign),
    .o_big    (w_big),
    .o_is_min (w_is_min),
    .o_int    (w_int),
    .o_guard  (w_guard),
    .o_sticky (w_sticky)
  );

  assign w_s2_adv = !out_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_class  <= FP_ZERO;
      r_s1_rnd    <= RND_RTZ;
      r_s1_sign   <= 1'b0;
      r_s1_big    <= 1'b0;
      r_s1_min    <= 1'b0;
      r_s1_int    <= '0;
      r_s1_guard  <= 1'b0;
      r_s1_sticky <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_class  <= w_class;
        r_s1_rnd    <= in_rnd_mode;
        r_s1_sign   <= w_sign;
        r_s1_big    <= w_big;
        r_s1_min    <= w_is_min;
        r_s1_int    <= w_int;
        r_s1_guard  <= w_guard;
        r_s1_sticky <= w_sticky;
      end
    end
  end

  // Round, negate, then let exceptional classes override in priority order.
  always_comb begin
    w_inc = 1'b0;
    case (r_s1_rnd)
      RND_RNE: w_inc = r_s1_guard && (r_s1_sticky || r_s1_int[0]);
      RND_RTZ: w_inc = 1'b0;
      default: w_inc = 1'b0;
    endcase
    w_mag   = {1'b0, r_s1_int} + {31'b0, w_inc};
    w_data  = r_s1_sign ? (~w_mag + 32'd1) : w_mag;
    w_flags = '0;
    w_flags[FLAG_INEXACT] = r_s1_guard || r_s1_sticky;
    if (r_s1_class == FP_NAN) begin
      w_data  = NAN_VALUE;
      w_flags = '0;
      w_flags[FLAG_INVALID] = 1'b1;
    end else if (r_s1_min) begin
      w_data  = 32'h8000_0000;
      w_flags = '0;
    end else if (r_s1_class == FP_INF || r_s1_big) begin
      w_data  = r_s1_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
      w_flags = '0;
      w_flags[FLAG_OVERFLOW] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else if (w_s2_adv) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_data  <= w_data;
        out_flags <= w_flags;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp32_to_int32.sv
// ============================================================================
// tb_fp32_to_int32 : directed vector table plus streaming, backpressure and
//                    mid-stream reset sequences for fp32_to_int32
// Revision         : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fp32_to_int32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_rnd_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_flags;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  fp32_to_int32 #(.NAN_VALUE(32'h7FFF_FFFF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_rnd_mode (in_rnd_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_flags   (out_flags)
  );

  typedef struct {
    logic [31:0] din;
    logic        rne;
    logic [31:0] dout;
    logic [2:0]  flags;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int idx);
    in_valid    = 1'b1;
    in_data     = vecs[idx].din;
    in_rnd_mode = vecs[idx].rne;
  endtask

  int   w, got, sent;
  logic acc;

  initial begin
    vecs[0]  = '{32'h3FC0_0000, 1'b1, 32'h0000_0002, 3'b001};
    vecs[1]  = '{32'h3FC0_0000, 1'b0, 32'h0000_0001, 3'b001};
    vecs[2]  = '{32'h4020_0000, 1'b1, 32'h0000_0002, 3'b001};
    vecs[3]  = '{32'hC060_0000, 1'b1, 32'hFFFF_FFFC, 3'b001};
    vecs[4]  = '{32'h4F00_0000, 1'b1, 32'h7FFF_FFFF, 3'b010};
    vecs[5]  = '{32'hCF00_0000, 1'b1, 32'h8000_0000, 3'b000};
    vecs[6]  = '{32'h7FC0_0000, 1'b1, 32'h7FFF_FFFF, 3'b100};
    vecs[7]  = '{32'hFF80_0000, 1'b1, 32'h8000_0000, 3'b010};
    vecs[8]  = '{32'h0000_0000, 1'b1, 32'h0000_0000, 3'b000};
    vecs[9]  = '{32'h0000_0001, 1'b1, 32'h0000_0000, 3'b001};
    vecs[10] = '{32'h3F00_0000, 1'b1, 32'h0000_0000, 3'b001};
    vecs[11] = '{32'h3F40_0000, 1'b1, 32'h0000_0001, 3'b001};
    vecs[12] = '{32'h3F40_0000, 1'b0, 32'h0000_0000, 3'b001};
    vecs[13] = '{32'hBF80_0000, 1'b1, 32'hFFFF_FFFF, 3'b000};
    vecs[14] = '{32'h4EFF_FFFF, 1'b1, 32'h7FFF_FF80, 3'b000};
    vecs[15] = '{32'h7F80_0000, 1'b0, 32'h7FFF_FFFF, 3'b010};
    vecs[16] = '{32'hCF00_0001, 1'b0, 32'h8000_0000, 3'b010};
    vecs[17] = '{32'h8000_0000, 1'b1, 32'h0000_0000, 3'b000};
    vecs[18] = '{32'h4AFF_FFFF, 1'b1, 32'h0080_0000, 3'b001};
    vecs[19] = '{32'hBF7F_FFFF, 1'b0, 32'h0000_0000, 3'b001};
    vecs[20] = '{32'h4B00_0001, 1'b1, 32'h0080_0001, 3'b000};
    vecs[21] = '{32'hFFC0_0001, 1'b0, 32'h7FFF_FFFF, 3'b100};

    // Reset state
    tick();
    tick();
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", out_data, 32'd0);
    chk("reset out_flags", 32'(out_flags), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Single-word vectors
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      send(i);
      tick();
      in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 10) begin
        tick();
        w++;
      end
      if (!out_valid) chk($sformatf("vec%0d timeout", i), 32'(out_valid), 32'd1);
      else begin
        if (i == 0) chk("latency", 32'(w), 32'd1);
        chk($sformatf("vec%0d data", i), out_data, vecs[i].dout);
        chk($sformatf("vec%0d flags", i), 32'(out_flags), 32'(vecs[i].flags));
      end
      tick();
    end

    // Back-to-back stream, no gaps
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        send(c);
        chk($sformatf("stream in_ready c%0d", c), 32'(in_ready), 32'd1);
      end else in_valid = 1'b0;
      tick();
      if (c >= 1 && c <= 8) begin
        chk($sformatf("stream valid c%0d", c), 32'(out_valid), 32'd1);
        chk($sformatf("stream data c%0d", c), out_data, vecs[c-1].dout);
        chk($sformatf("stream flags c%0d", c), 32'(out_flags), 32'(vecs[c-1].flags));
      end else begin
        chk($sformatf("stream idle c%0d", c), 32'(out_valid), 32'd0);
      end
    end

    // Backpressure: words 0, 3, 4 -> results 2, -4, +sat
    out_ready = 1'b0;
    send(0);
    #1;
    chk("bp in_ready empty", 32'(in_ready), 32'd1);
    tick();
    send(3);
    chk("bp in_ready s2 empty", 32'(in_ready), 32'd1);
    tick();
    send(4);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp in_ready stall%0d", c), 32'(in_ready), 32'd0);
      chk($sformatf("bp valid stall%0d", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp data stall%0d", c), out_data, vecs[0].dout);
      tick();
    end
    out_ready = 1'b1;
    #1;
    got  = 0;
    sent = 2;
    for (int c = 0; c < 8; c++) begin
      acc = in_valid && in_ready;
      if (out_valid) begin
        if (got == 0)      chk("bp drain0", out_data, vecs[0].dout);
        else if (got == 1) chk("bp drain1", out_data, vecs[3].dout);
        else if (got == 2) chk("bp drain2", out_data, vecs[4].dout);
        else               chk("bp extra output", 32'(out_valid), 32'd0);
        got++;
      end
      tick();
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    chk("bp output count", 32'(got), 32'd3);

    // Reset with two words in flight
    out_ready = 1'b0;
    send(2);
    tick();
    send(3);
    tick();
    in_valid = 1'b0;
    chk("rst pre out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst async out_valid", 32'(out_valid), 32'd0);
    chk("rst async out_data", out_data, 32'd0);
    chk("rst async out_flags", 32'(out_flags), 32'd0);
    chk("rst async in_ready", 32'(in_ready), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("rst ghost c%0d", c), 32'(out_valid), 32'd0);
    end
    send(5);
    tick();
    in_valid = 1'b0;
    tick();
    chk("post-rst valid", 32'(out_valid), 32'd1);
    chk("post-rst data", out_data, vecs[5].dout);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
